// File: rtl/branch_redirect_ctrl_if.sv
// Bundle of fetch-query, EX-resolution and redirect/flush signals shared
// between the branch redirect controller and the rest of the core.
interface branch_redirect_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             query_valid;
  logic [WIDTH-1:0] query_pc;
  logic             pred_taken;

  logic             res_valid;
  logic             res_is_branch;
  logic             res_is_jump;
  logic             res_taken;
  logic             res_pred_taken;
  logic [WIDTH-1:0] res_pc;
  logic [WIDTH-1:0] res_target;

  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             redirect_ready;
  logic             flush;
  logic [CNT_W-1:0] mispredict_count;

  // Core side: drives queries, resolutions and the redirect acceptance
  modport master (
    output query_valid, query_pc,
    output res_valid, res_is_branch, res_is_jump, res_taken, res_pred_taken,
    output res_pc, res_target, redirect_ready,
    input  pred_taken, redirect_valid, redirect_pc, flush, mispredict_count
  );

  // Controller side
  modport slave (
    input  query_valid, query_pc,
    input  res_valid, res_is_branch, res_is_jump, res_taken, res_pred_taken,
    input  res_pc, res_target, redirect_ready,
    output pred_taken, redirect_valid, redirect_pc, flush, mispredict_count
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: bimodal direction table for fetch, mispredict
// detection at EX, redirect handshake to fetch and a fixed flush window.
module branch_redirect_ctrl #(
  parameter int WIDTH        = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_redirect_ctrl_if.slave ctrl
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  // Down-counter only needs to hold FLUSH_CYCLES-1; keep at least one bit
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FCW'(FLUSH_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             redirValid_q, redirValid_d;
  logic [WIDTH-1:0] redirPc_q, redirPc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] missCnt_q, missCnt_d;
  logic [FCW-1:0]   flushCnt_q, flushCnt_d;
  logic [1:0]       bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0] queryIdx;
  logic [IDX_W-1:0] resIdx;
  logic             resAccept;
  logic             actualTaken;
  logic             mispredict;
  logic             train;
  logic [WIDTH-1:0] correctedPc;
  logic             unusedQueryBits;

  // Word-aligned PCs: the two low bits never select a table entry
  assign queryIdx = ctrl.query_pc[IDX_W+1:2];
  assign resIdx   = ctrl.res_pc[IDX_W+1:2];
  assign unusedQueryBits = ^{ctrl.query_pc[WIDTH-1:IDX_W+2], ctrl.query_pc[1:0]};

  // Resolutions only count while idle; anything else is wrong-path traffic.
  // A jump outranks the branch flag and is always actually taken.
  assign resAccept   = (state_q == ST_IDLE) & ctrl.res_valid &
                       (ctrl.res_is_branch | ctrl.res_is_jump);
  assign actualTaken = ctrl.res_is_jump | ctrl.res_taken;
  assign mispredict  = resAccept & (actualTaken != ctrl.res_pred_taken);
  assign train       = resAccept & ~ctrl.res_is_jump;
  assign correctedPc = actualTaken ? ctrl.res_target : (ctrl.res_pc + WIDTH'(4));

  // Prediction reads the registered table, so a same-cycle update is not seen
  assign ctrl.pred_taken       = ctrl.query_valid & bht_q[queryIdx][1];
  assign ctrl.redirect_valid   = redirValid_q;
  assign ctrl.redirect_pc      = redirPc_q;
  assign ctrl.flush            = flush_q;
  assign ctrl.mispredict_count = missCnt_q;

  // Next-state logic for the redirect/flush sequencer
  always_comb begin
    state_d      = state_q;
    redirValid_d = redirValid_q;
    redirPc_d    = redirPc_q;
    flush_d      = flush_q;
    missCnt_d    = missCnt_q;
    flushCnt_d   = flushCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d      = ST_REDIRECT;
          redirValid_d = 1'b1;
          redirPc_d    = correctedPc;
          flush_d      = 1'b1;
          if (missCnt_q != '1) begin
            missCnt_d = missCnt_q + CNT_W'(1);
          end
        end
      end
      ST_REDIRECT: begin
        if (ctrl.redirect_ready) begin
          redirValid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_d    = ST_FLUSH;
            flush_d    = 1'b1;
            flushCnt_d = FLUSH_LOAD;
          end else begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (flushCnt_q == '0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          flushCnt_d = flushCnt_q - FCW'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        redirValid_d = 1'b0;
        flush_d      = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset abandons any redirect or flush in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      redirValid_q <= 1'b0;
      redirPc_q    <= '0;
      flush_q      <= 1'b0;
      missCnt_q    <= '0;
      flushCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      redirValid_q <= redirValid_d;
      redirPc_q    <= redirPc_d;
      flush_q      <= flush_d;
      missCnt_q    <= missCnt_d;
      flushCnt_q   <= flushCnt_d;
    end
  end

  // Direction table: 2-bit saturating counters, trained by accepted branches
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (train) begin
      if (ctrl.res_taken) begin
        if (bht_q[resIdx] != 2'b11) begin
          bht_q[resIdx] <= bht_q[resIdx] + 2'b01;
        end
      end else begin
        if (bht_q[resIdx] != 2'b00) begin
          bht_q[resIdx] <= bht_q[resIdx] - 2'b01;
        end
      end
    end
  end

endmodule
